imem_loader: RTL

//  Writer side of the instruction memory: drives the imem port-A write interface that the CPU

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader_byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int LOADER_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_LEN     = 2'b01,
    ERR_CSUM    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } loader_err_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem port-A write bus of the loader.
// slave = loader side, master = environment (UART RX source / imem).
interface imem_loader_if #(
  parameter int ARCH            = 32,
  parameter int IMEM_ADDR_WIDTH = 12
);
  logic [7:0]                 rx_data_in;
  logic                       rx_valid_in;
  logic                       rx_ready_out;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr_out;
  logic [ARCH-1:0]            imem_data_out;
  logic                       imem_we_out;

  modport slave (
    input  rx_data_in, rx_valid_in,
    output rx_ready_out, imem_addr_out, imem_data_out, imem_we_out
  );

  modport master (
    output rx_data_in, rx_valid_in,
    input  rx_ready_out, imem_addr_out, imem_data_out, imem_we_out
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs little-endian bytes into ARCH-bit words. assembled_o shows the word
// including the byte currently offered, so the caller can act on the 4th byte
// in the same cycle; word_valid_o pulses the cycle after a 4th byte when emit_i.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int ARCH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            byte_valid_i,
  input  logic            emit_i,
  input  logic [7:0]      byte_i,
  output logic            last_byte_o,
  output logic [ARCH-1:0] assembled_o,
  output logic [ARCH-1:0] word_o,
  output logic            word_valid_o
);

  logic [1:0]      idx_q;
  logic [ARCH-1:0] word_q;
  logic            word_valid_q;

  assign last_byte_o  = byte_valid_i && (idx_q == 2'(LOADER_BYTES_PER_WORD - 1));
  assign assembled_o  = {byte_i, word_q[ARCH-1:8]};
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

  // Shift each accepted byte in from the top; after four bytes byte 0 sits in [7:0].
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      idx_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= last_byte_o && emit_i;
      if (byte_valid_i) begin
        idx_q  <= idx_q + 2'd1;
        word_q <= assembled_o;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed program image over a byte
// stream, writes it to imem port A and releases the CPU reset on success.
//
//  state | meaning
//  IDLE  | after reset, waiting for load_req, CPU held in reset
//  LEN   | receiving the 4-byte little-endian word count N
//  DATA  | receiving N payload words, each written to imem
//  CSUM  | waiting for the XOR checksum byte
//  DONE  | image accepted, CPU released (sticky until next load_req)
//  ERR   | load failed, err_code holds the reason, CPU stays in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ARCH             = 32,
  parameter int IMEM_DEPTH_BYTES = 4096,
  parameter int IMEM_ADDR_WIDTH  = 12,
  parameter int TIMEOUT_CYCLES   = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_req_in,
  imem_loader_if.slave bus,
  output logic         cpu_rst_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         err_out,
  output logic [1:0]   err_code_out
);

  localparam int MAX_WORDS = IMEM_DEPTH_BYTES / LOADER_BYTES_PER_WORD;
  localparam int IDX_W     = IMEM_ADDR_WIDTH - 2;
  localparam int TIMER_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

  loader_state_t      state_q;
  loader_err_t        err_code_q;
  logic               ready_q;
  logic               cpu_rst_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [7:0]         xor_q;
  logic [ARCH-1:0]    words_left_q;
  logic [IDX_W-1:0]   word_idx_q;
  logic [TIMER_W-1:0] timer_q;

  logic            load_start;
  logic            accept;
  logic            pk_last;
  logic [ARCH-1:0] pk_assembled;
  logic [ARCH-1:0] pk_word;
  logic            pk_word_valid;

  assign load_start = ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR)) && load_req_in;
  assign accept     = bus.rx_valid_in && ready_q;

  imem_loader_byte_packer #(.ARCH(ARCH)) u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (load_start),
    .byte_valid_i (accept),
    .emit_i       (state_q == DATA),
    .byte_i       (bus.rx_data_in),
    .last_byte_o  (pk_last),
    .assembled_o  (pk_assembled),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  assign bus.rx_ready_out  = ready_q;
  assign bus.imem_we_out   = pk_word_valid;
  assign bus.imem_data_out = pk_word;
  assign bus.imem_addr_out = {word_idx_q, 2'b00};

  assign cpu_rst_out  = cpu_rst_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign err_out      = err_q;
  assign err_code_out = err_code_q;

  // Load sequencing FSM; every status output is a flop updated with the state.
  // The gap timer is a down-counter reloaded on each accepted byte and on entry
  // to LEN; an accepted byte takes priority over its terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      err_code_q   <= ERR_NONE;
      ready_q      <= 1'b0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      xor_q        <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      timer_q      <= '0;
    end else begin
      if (pk_word_valid) begin
        word_idx_q <= word_idx_q + IDX_W'(1);
      end

      if (load_start) begin
        state_q    <= LEN;
        err_code_q <= ERR_NONE;
        ready_q    <= 1'b1;
        cpu_rst_q  <= 1'b1;
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
        xor_q      <= '0;
        word_idx_q <= '0;
        timer_q    <= TIMER_LOAD;
      end else if (busy_q) begin
        if (accept) begin
          timer_q <= TIMER_LOAD;
          case (state_q)
            LEN: begin
              if (pk_last) begin
                if (pk_assembled == '0) begin
                  state_q <= CSUM;
                end else if (pk_assembled > ARCH'(MAX_WORDS)) begin
                  state_q    <= ERR;
                  err_code_q <= ERR_LEN;
                  err_q      <= 1'b1;
                  ready_q    <= 1'b0;
                  busy_q     <= 1'b0;
                end else begin
                  state_q      <= DATA;
                  words_left_q <= pk_assembled;
                end
              end
            end
            DATA: begin
              xor_q <= xor_q ^ bus.rx_data_in;
              if (pk_last) begin
                words_left_q <= words_left_q - ARCH'(1);
                if (words_left_q == ARCH'(1)) begin
                  state_q <= CSUM;
                end
              end
            end
            CSUM: begin
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              if (bus.rx_data_in == xor_q) begin
                state_q   <= DONE;
                done_q    <= 1'b1;
                cpu_rst_q <= 1'b0;
              end else begin
                state_q    <= ERR;
                err_code_q <= ERR_CSUM;
                err_q      <= 1'b1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end else if (timer_q == '0) begin
          state_q    <= ERR;
          err_code_q <= ERR_TIMEOUT;
          err_q      <= 1'b1;
          ready_q    <= 1'b0;
          busy_q     <= 1'b0;
        end else begin
          timer_q <= timer_q - TIMER_W'(1);
        end
      end
    end
  end

endmodule
